relu_seq_ctrl: RTL and testbench
================================

# relu_seq_ctrl

Sequencer for the lane-parallel ReLU array that sits between the systolic-array result stream and the output feature-map buffer. It accepts a job (vector count, lane mask, base address), turns upstream valid/ready beats into per-lane `en` strobes for the array, and uses the array's output registers as the pipeline stage. It presents each rectified vector downstream with a ready/valid handshake and a write address, then pulses `done` when the last vector has been accepted.

## Interface
- `data_width`, 16, lane width of the ReLU array it drives (informational; passed through at the parent).
- `array_size`, 9, number of lanes; width of `en`, `lane_mask`, `out_lane_valid`.
- `cnt_width`, 10, width of the vector count.
- `addr_width`, 10, width of the output buffer address.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  job launch pulse; sampled only in IDLE.
- `num_vectors`  in  cnt_width  vectors in the job; sampled with `start`.
- `lane_mask`  in  array_size  active lanes; sampled with `start`.
- `base_addr`  in  addr_width  first write address; sampled with `start`.
- `in_valid`  in  1  upstream vector present on the array's `in` bus.
- `in_ready`  out  1  controller accepts the upstream vector this cycle.
- `en`  out  array_size  per-lane load strobe to the ReLU array.
- `out_valid`  out  1  array outputs hold an unconsumed vector.
- `out_ready`  in  1  downstream accepts the vector.
- `out_lane_valid`  out  array_size  lanes meaningful in the current output (registered mask).
- `wr_addr`  out  addr_width  buffer address for the current output vector.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at job end.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`. Latch `num_vectors` into `in_left` and `out_left`, latch `lane_mask` into `mask_q`, and load `wr_addr` with `base_addr`.
  - If `num_vectors` = 0 at start, go IDLE → DONE directly.
  - RUN → DONE when the final output beat is accepted (`out_left` = 1 and `out_valid` & `out_ready`).
  - DONE → IDLE unconditionally. `done` = 1 only in DONE.
- `start` outside IDLE is ignored.
- Input side:
  - `in_ready` = RUN & (`in_left` ≠ 0) & (!`out_valid` | `out_ready`).
  - `in_fire` = `in_valid` & `in_ready`.
  - `en` = {array_size{`in_fire`}} & `mask_q`. This is combinational, and masked lanes are never strobed.
  - Each `in_fire` decrements `in_left`.
- Output side:
  - `out_valid` sets on the cycle after `in_fire`.
  - `out_valid` clears after `out_ready` if there was no new fire in that cycle. On a simultaneous accept and fire, it stays 1.
  - Each accepted beat decrements `out_left` and increments `wr_addr`, which wraps modulo 2^addr_width.
- `out_lane_valid` = `mask_q`.
- Reset values: state IDLE; `in_ready`, `en`, `out_valid`, `busy`, `done` = 0; `out_lane_valid`, `wr_addr`, and the counters = 0.
- Reset mid-job aborts immediately. `done` is not pulsed, and any in-flight array data is discarded by clearing `out_valid`.

## Timing
- ReLU array latency is 1 cycle. Data strobed at cycle N is on the array outputs at N+1, with `out_valid` = 1 at N+1.
- With `out_ready` held high and `in_valid` held high, throughput is 1 vector/cycle with no bubbles.
- `wr_addr` is stable while `out_valid` is high and not accepted.
- `done` comes 1 cycle after the final accept; `busy` falls one cycle after `done`.
- Stall: with `out_ready` = 0 and `out_valid` = 1, `in_ready` = 0 and `en` = 0. The array registers hold the vector.

## Structure
- Package `relu_ctrl_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - default `array_size`, `cnt_width`, and `addr_width` constants.
- One sub-module, `beat_counter`: a load/decrement down-counter with a zero flag, instantiated twice, for `in_left` and `out_left`.
- The ReLU array is instantiated beside this block at the parent, not inside it.

## Test plan
- Basic job: `num_vectors` = 4, mask = all ones, `base_addr` = 0x10, `out_ready` = 1, back-to-back inputs.
  - Expect `en` = 0x1FF for 4 consecutive cycles.
  - Expect outputs at addresses 0x10–0x13.
  - Expect `done` pulse 1 cycle after the 4th accept.
- Backpressure: same job with `out_ready` low for 3 cycles after the first output.
  - Expect `in_ready` = 0, `en` = 0, and `wr_addr` held at 0x10.
  - Expect no vector lost or duplicated; 4 beats total.
- Lane mask: mask = 9'b000000101, `num_vectors` = 2.
  - Expect `en` = 0x005 on each fire.
  - Expect `out_lane_valid` = 0x005.
- Zero length: `start` with `num_vectors` = 0.
  - Expect `in_ready` never asserts.
  - Expect `done` on the cycle after `start` and `busy` high for exactly 1 cycle.
- Edge cases: `start` pulsed again during RUN; `base_addr` = 2^addr_width−1 with 2 vectors; `reset` asserted mid-job.
  - Repeated `start` is ignored.
  - `wr_addr` wraps to 0.
  - After reset, all outputs return to 0 the next cycle and no `done` pulse occurs.

Source files
------------

// File: rtl/relu_ctrl_pkg.sv
// Shared types and default sizes for the ReLU array sequencer.
package relu_ctrl_pkg;

    localparam int ARRAY_SIZE = 9;
    localparam int CNT_WIDTH  = 10;
    localparam int ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/relu_seq_ctrl_if.sv
// Job, upstream and downstream handshake signals of the ReLU array sequencer.
import relu_ctrl_pkg::*;

interface relu_seq_ctrl_if;

    logic                  start;
    logic [CNT_WIDTH-1:0]  num_vectors;
    logic [ARRAY_SIZE-1:0] lane_mask;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  in_valid;
    logic                  in_ready;
    logic [ARRAY_SIZE-1:0] en;
    logic                  out_valid;
    logic                  out_ready;
    logic [ARRAY_SIZE-1:0] out_lane_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  busy;
    logic                  done;

    // Job source / upstream / downstream side
    modport master (
        output start, num_vectors, lane_mask, base_addr, in_valid, out_ready,
        input  in_ready, en, out_valid, out_lane_valid, wr_addr, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, num_vectors, lane_mask, base_addr, in_valid, out_ready,
        output in_ready, en, out_valid, out_lane_valid, wr_addr, busy, done
    );

endinterface

// File: rtl/beat_counter.sv
// Loadable down-counter with zero flag; holds at zero rather than wrapping.
module beat_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    // Load has priority over decrement
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/relu_seq_ctrl.sv
// Sequencer for the lane-parallel ReLU array: converts upstream beats into
// per-lane load strobes and presents the array outputs downstream with an
// incrementing write address. The array registers are the only data stage.
//
//   state   | meaning
//   --------+----------------------------------------------
//   IDLE    | waiting for start; job parameters sampled here
//   RUN     | moving vectors through the array
//   DONE    | one-cycle done pulse, then back to IDLE
import relu_ctrl_pkg::*;

module relu_seq_ctrl (
    input  logic           clk,
    input  logic           reset,
    relu_seq_ctrl_if.slave bus
);

    state_e                state_q, state_d;
    logic [ARRAY_SIZE-1:0] mask_q, mask_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  out_valid_q, out_valid_d;

    logic [CNT_WIDTH-1:0]  in_left, out_left;
    logic                  in_zero, out_zero;
    logic                  job_load, in_ready, in_fire, out_accept, last_accept;
    logic                  unused_cnt;

    assign job_load    = (state_q == ST_IDLE) && bus.start;
    // A new vector may enter only if the array output slot is free or is being drained
    assign in_ready    = (state_q == ST_RUN) && !in_zero && (!out_valid_q || bus.out_ready);
    assign in_fire     = bus.in_valid && in_ready;
    assign out_accept  = out_valid_q && bus.out_ready;
    assign last_accept = out_accept && (out_left == CNT_WIDTH'(1));

    beat_counter #(.WIDTH(CNT_WIDTH)) u_in_left (
        .clk        (clk),
        .reset      (reset),
        .load_i     (job_load),
        .load_val_i (bus.num_vectors),
        .dec_i      (in_fire),
        .count_o    (in_left),
        .zero_o     (in_zero)
    );

    beat_counter #(.WIDTH(CNT_WIDTH)) u_out_left (
        .clk        (clk),
        .reset      (reset),
        .load_i     (job_load),
        .load_val_i (bus.num_vectors),
        .dec_i      (out_accept),
        .count_o    (out_left),
        .zero_o     (out_zero)
    );

    // Only the zero flag of the input counter and the count of the output counter are needed
    assign unused_cnt = ^{in_left, out_zero};

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        wr_addr_d   = wr_addr_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.num_vectors == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_accept) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (job_load) begin
            mask_d    = bus.lane_mask;
            wr_addr_d = bus.base_addr;
        end else if (out_accept) begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        end

        // A fire refills the slot even when the current vector is accepted
        if (in_fire) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and control registers; reset drops any in-flight vector
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            wr_addr_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            wr_addr_q   <= wr_addr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.en             = {ARRAY_SIZE{in_fire}} & mask_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_lane_valid = mask_q;
    assign bus.wr_addr        = wr_addr_q;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Scoreboard bench for relu_seq_ctrl: jobs push expected output beats,
// a negedge monitor pops and compares each accepted beat.
module tb_relu_seq_ctrl;

    logic clk;
    logic reset;

    relu_seq_ctrl_if bus ();

    relu_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [9:0] addr;
        logic [8:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   last_acc_cyc = -10;
    int   done_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted output beat must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            acc_cnt++;
            last_acc_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got addr %0h expected no beat", bus.wr_addr);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                check("out_lane_valid", 32'(bus.out_lane_valid), 32'(e.mask));
            end
        end
        if (bus.done) done_total++;
    end

    task automatic run_job(input int n, input logic [8:0] m, input logic [9:0] base,
                           input int stall_len, input bit restart);
        int fires = 0;
        int waited = 0;
        int stalls = 0;
        int first_fire = -1;
        int last_fire = -1;
        int start_cyc;
        int acc0;
        int done0;
        bit seen_done = 0;
        bit fire;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.addr = base + 10'(i);
            e.mask = m;
            exp_q.push_back(e);
        end
        acc0  = acc_cnt;
        done0 = done_total;

        @(posedge clk); #1;
        start_cyc       = cyc;
        bus.start       = 1'b1;
        bus.num_vectors = 10'(n);
        bus.lane_mask   = m;
        bus.base_addr   = base;
        bus.in_valid    = 1'b1;
        bus.out_ready   = (stall_len == 0);
        @(negedge clk);
        check("busy_idle", 32'(bus.busy), 0);
        check("in_ready_idle", 32'(bus.in_ready), 0);
        @(posedge clk); #1;
        if (restart) begin
            bus.start       = 1'b1;
            bus.num_vectors = 10'd7;
            bus.base_addr   = 10'h155;
            bus.lane_mask   = 9'h1FF;
        end else begin
            bus.start = 1'b0;
        end

        while (!seen_done && waited < 64) begin
            @(negedge clk);
            waited++;
            fire = bus.in_valid && bus.in_ready;
            check("en", 32'(bus.en), fire ? 32'(m) : 32'd0);
            if (n == 0) check("in_ready_zero_len", 32'(bus.in_ready), 0);
            if (fire) begin
                fires++;
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("stall_in_ready", 32'(bus.in_ready), 0);
                check("stall_wr_addr", 32'(bus.wr_addr), 32'(base));
            end
            if (bus.done) begin
                seen_done = 1;
                check("done_cycle", 32'(cyc), (n == 0) ? 32'(start_cyc + 1) : 32'(last_acc_cyc + 1));
                check("busy_at_done", 32'(bus.busy), 1);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (stall_len > 0) begin
                if (stalls < stall_len && bus.out_valid) begin
                    stalls++;
                    bus.out_ready = 1'b0;
                end else if (stalls >= stall_len) begin
                    bus.out_ready = 1'b1;
                end
            end
        end

        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 64 cycles");
        end
        check("fires", 32'(fires), 32'(n));
        check("beats", 32'(acc_cnt - acc0), 32'(n));
        check("queue_empty", 32'(exp_q.size()), 0);
        check("done_pulses", 32'(done_total - done0), 1);
        if (stall_len > 0) check("stall_cycles", 32'(stalls), 32'(stall_len));
        if (stall_len == 0 && n > 0) check("back_to_back", 32'(last_fire - first_fire), 32'(n - 1));
        @(negedge clk);
        check("busy_after", 32'(bus.busy), 0);
        check("done_after", 32'(bus.done), 0);
        bus.in_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic reset_mid_job();
        int done0;
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e.addr = 10'h020 + 10'(i);
            e.mask = 9'h1FF;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.num_vectors = 10'd5;
        bus.lane_mask   = 9'h1FF;
        bus.base_addr   = 10'h020;
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_busy", 32'(bus.busy), 1);
        check("mid_out_valid", 32'(bus.out_valid), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        done0 = done_total;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_en", 32'(bus.en), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_lane_valid", 32'(bus.out_lane_valid), 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        check("rst_no_done", 32'(done_total - done0), 0);
        check("rst_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.num_vectors = '0;
        bus.lane_mask   = '0;
        bus.base_addr   = '0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 0);
        check("reset_en", 32'(bus.en), 0);
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_wr_addr", 32'(bus.wr_addr), 0);
        check("reset_lane_valid", 32'(bus.out_lane_valid), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_job(4, 9'h1FF, 10'h010, 0, 1'b0);   // basic back-to-back job
        run_job(4, 9'h1FF, 10'h010, 3, 1'b0);   // first output held 3 cycles
        run_job(2, 9'h005, 10'h040, 0, 1'b1);   // lane mask, start repeated in RUN
        run_job(0, 9'h1FF, 10'h000, 0, 1'b0);   // zero-length job
        run_job(2, 9'h1FF, 10'h3FF, 0, 1'b0);   // address wraps 0x3FF -> 0x000
        reset_mid_job();
        run_job(1, 9'h0F0, 10'h123, 0, 1'b0);   // clean job after abort

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
